// File: rtl/pid_channel_scheduler_if.sv
// Datapath-side bus of the PID channel scheduler: sensor read port,
// PID fire/result handshake and actuator write port.
interface pid_channel_scheduler_if #(
  parameter int CH_W = 3
);
  logic                   err_rd_en;
  logic        [CH_W-1:0] err_rd_addr;
  logic signed [15:0]     err_rd_data;
  logic                   pid_en;
  logic signed [15:0]     pid_err;
  logic signed [15:0]     pid_kp;
  logic signed [15:0]     pid_ki;
  logic signed [15:0]     pid_kd;
  logic                   pid_valid;
  logic signed [15:0]     pid_out;
  logic                   act_we;
  logic        [CH_W-1:0] act_addr;
  logic signed [15:0]     act_data;

  modport master (
    output err_rd_en, err_rd_addr,
    input  err_rd_data,
    output pid_en, pid_err,
    output pid_kp, pid_ki, pid_kd,
    input  pid_valid, pid_out,
    output act_we, act_addr, act_data
  );

  modport slave (
    input  err_rd_en, err_rd_addr,
    output err_rd_data,
    input  pid_en, pid_err,
    input  pid_kp, pid_ki, pid_kd,
    output pid_valid, pid_out,
    input  act_we, act_addr, act_data
  );
endinterface

// File: rtl/pid_channel_scheduler.sv
// Shares one PID datapath across NUM_CH actuator channels per frame.
// Ports: clk, rst_n (async low), frame_start, busy, frame_done,
// bus (master: sensor rd / PID / actuator wr), cfg_* gain bank write,
// clear_err, sticky timeout_err / overrun_err.
// Option PID_SCHED_CHMASK_EN adds ch_mask to skip channels.
module pid_channel_scheduler #(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  output logic                   busy,
  output logic                   frame_done,
  pid_channel_scheduler_if.master bus,
  input  logic                   cfg_we,
  input  logic        [CH_W-1:0] cfg_ch,
  input  logic        [1:0]      cfg_sel,
  input  logic signed [15:0]     cfg_wdata,
  input  logic                   clear_err,
  output logic                   timeout_err,
  output logic                   overrun_err
`ifdef PID_SCHED_CHMASK_EN
  ,
  input  logic [NUM_CH-1:0]      ch_mask
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ?
                         $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0] LAST_CH =
    CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0] CH_LIM =
    (CH_W + 1)'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ERR,
    S_CAPTURE,
    S_ISSUE,
    S_WAIT_PID,
    S_WRITE,
    S_NEXT,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [15:0] kp_q [NUM_CH];
  logic signed [15:0] kp_d [NUM_CH];
  logic signed [15:0] ki_q [NUM_CH];
  logic signed [15:0] ki_d [NUM_CH];
  logic signed [15:0] kd_q [NUM_CH];
  logic signed [15:0] kd_d [NUM_CH];

  logic               rd_en_q, rd_en_d;
  logic [CH_W-1:0]    rd_addr_q, rd_addr_d;
  logic               pid_en_q, pid_en_d;
  logic signed [15:0] pid_err_q, pid_err_d;
  logic signed [15:0] pid_kp_q, pid_kp_d;
  logic signed [15:0] pid_ki_q, pid_ki_d;
  logic signed [15:0] pid_kd_q, pid_kd_d;
  logic               act_we_q, act_we_d;
  logic [CH_W-1:0]    act_addr_q, act_addr_d;
  logic signed [15:0] act_data_q, act_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               ovr_q, ovr_d;
  logic               tmo_set;
  logic               ovr_set;
  logic               cfg_ok;

  logic [CH_W-1:0] first_ch;
  logic            first_ok;
  logic [CH_W-1:0] nxt_ch;
  logic            nxt_ok;

`ifdef PID_SCHED_CHMASK_EN
  logic [NUM_CH-1:0] mask_q, mask_d;
`endif

  assign bus.err_rd_en   = rd_en_q;
  assign bus.err_rd_addr = rd_addr_q;
  assign bus.pid_en      = pid_en_q;
  assign bus.pid_err     = pid_err_q;
  assign bus.pid_kp      = pid_kp_q;
  assign bus.pid_ki      = pid_ki_q;
  assign bus.pid_kd      = pid_kd_q;
  assign bus.act_we      = act_we_q;
  assign bus.act_addr    = act_addr_q;
  assign bus.act_data    = act_data_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign timeout_err     = tmo_q;
  assign overrun_err     = ovr_q;

  assign cfg_ok = cfg_we &&
                  ({1'b0, cfg_ch} < CH_LIM) &&
                  (cfg_sel != 2'd3);

  // Gain bank: flop outputs are read by CAPTURE, so a
  // same-cycle write only lands for the next frame.
  always_comb begin
    kp_d = kp_q;
    ki_d = ki_q;
    kd_d = kd_q;
    if (cfg_ok) begin
      case (cfg_sel)
        2'd0:    kp_d[cfg_ch] = cfg_wdata;
        2'd1:    ki_d[cfg_ch] = cfg_wdata;
        2'd2:    kd_d[cfg_ch] = cfg_wdata;
        default: ;
      endcase
    end
  end

  // First and next channel to visit; descending loops so the
  // lowest qualifying index wins.
  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    nxt_ch   = '0;
    nxt_ok   = 1'b0;
`ifdef PID_SCHED_CHMASK_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch = CH_W'(i);
        first_ok = 1'b1;
      end
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch = CH_W'(i);
        nxt_ok = 1'b1;
      end
    end
`else
    first_ok = 1'b1;
    nxt_ch   = ch_q + 1'b1;
    nxt_ok   = (ch_q != LAST_CH);
`endif
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    pid_en_d   = 1'b0;
    pid_err_d  = pid_err_q;
    pid_kp_d   = pid_kp_q;
    pid_ki_d   = pid_ki_q;
    pid_kd_d   = pid_kd_q;
    act_we_d   = 1'b0;
    act_addr_d = act_addr_q;
    act_data_d = act_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmo_set    = 1'b0;
    ovr_set    = frame_start && (state_q != S_IDLE);
`ifdef PID_SCHED_CHMASK_EN
    mask_d     = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          busy_d = 1'b1;
          ch_d   = first_ch;
`ifdef PID_SCHED_CHMASK_EN
          mask_d = ch_mask;
`endif
          if (first_ok) begin
            state_d   = S_RD_ERR;
            rd_en_d   = 1'b1;
            rd_addr_d = first_ch;
          end else begin
            // Empty mask: NEXT finds nothing and ends the frame.
            state_d = S_NEXT;
          end
        end
      end
      S_RD_ERR: state_d = S_CAPTURE;
      S_CAPTURE: begin
        pid_err_d = bus.err_rd_data;
        pid_kp_d  = kp_q[ch_q];
        pid_ki_d  = ki_q[ch_q];
        pid_kd_d  = kd_q[ch_q];
        pid_en_d  = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_PID;
      end
      S_WAIT_PID: begin
        if (bus.pid_valid) begin
          act_data_d = bus.pid_out;
          act_addr_d = ch_q;
          act_we_d   = 1'b1;
          state_d    = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_set = 1'b1;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (nxt_ok) begin
          ch_d      = nxt_ch;
          rd_en_d   = 1'b1;
          rd_addr_d = nxt_ch;
          state_d   = S_RD_ERR;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        ch_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Set beats clear when both land in one cycle.
    tmo_d = (tmo_q & ~clear_err) | tmo_set;
    ovr_d = (ovr_q & ~clear_err) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pid_en_q   <= 1'b0;
      pid_err_q  <= '0;
      pid_kp_q   <= '0;
      pid_ki_q   <= '0;
      pid_kd_q   <= '0;
      act_we_q   <= 1'b0;
      act_addr_q <= '0;
      act_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ovr_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        kp_q[i] <= '0;
        ki_q[i] <= '0;
        kd_q[i] <= '0;
      end
`ifdef PID_SCHED_CHMASK_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pid_en_q   <= pid_en_d;
      pid_err_q  <= pid_err_d;
      pid_kp_q   <= pid_kp_d;
      pid_ki_q   <= pid_ki_d;
      pid_kd_q   <= pid_kd_d;
      act_we_q   <= act_we_d;
      act_addr_q <= act_addr_d;
      act_data_q <= act_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      ovr_q      <= ovr_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
`ifdef PID_SCHED_CHMASK_EN
      mask_q     <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed self-checking bench for pid_channel_scheduler.
// Models a registered sensor buffer and a 1-cycle PID echo.
module tb_pid_channel_scheduler;
  localparam int NCH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic cfg_we = 1'b0;
  logic clear_err = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic signed [15:0] cfg_wdata = '0;
  logic busy, frame_done, timeout_err, overrun_err;
`ifdef PID_SCHED_CHMASK_EN
  logic [NCH-1:0] ch_mask = '0;
`endif

  pid_channel_scheduler_if #(.CH_W(3)) bus ();

  pid_channel_scheduler #(
    .NUM_CH(NCH), .CH_W(3), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_start(frame_start),
    .busy(busy), .frame_done(frame_done),
    .bus(bus),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .clear_err(clear_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
`ifdef PID_SCHED_CHMASK_EN
    , .ch_mask(ch_mask)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cnt = 0;
  int start_cyc = 0;
  int drop_ch = -1;
  logic [2:0] cur_ch = '0;
  logic [2:0] wa[$];
  logic signed [15:0] wd[$];
  logic signed [15:0] err_mem [NCH];
  logic signed [15:0] seen_kp [NCH];
  logic signed [15:0] seen_ki [NCH];
  logic signed [15:0] seen_kd [NCH];
  int exp_a [NCH] = '{-50, 7, 100, 66, -40, 1234, 250, -300};

  always @(posedge clk or negedge rst_n)
    if (!rst_n) bus.err_rd_data <= '0;
    else if (bus.err_rd_en)
      bus.err_rd_data <= err_mem[bus.err_rd_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pid_valid <= 1'b0;
      bus.pid_out   <= '0;
    end else begin
      bus.pid_valid <= 1'b0;
      if (bus.pid_en) begin
        seen_kp[cur_ch] <= bus.pid_kp;
        seen_ki[cur_ch] <= bus.pid_ki;
        seen_kd[cur_ch] <= bus.pid_kd;
        if (int'(cur_ch) != drop_ch) begin
          bus.pid_valid <= 1'b1;
          bus.pid_out <= 16'((int'(bus.pid_err) *
                              int'(bus.pid_kp)) >>> 4);
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.act_we) begin
      wa.push_back(bus.act_addr);
      wd.push_back(bus.act_data);
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.err_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      cur_ch <= bus.err_rd_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int sel,
                           input int val);
    tick();
    cfg_we = 1'b1;
    cfg_ch = 3'(ch);
    cfg_sel = 2'(sel);
    cfg_wdata = 16'(val);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_frame();
    tick();
    frame_start = 1'b1;
    start_cyc = cyc;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, frame_done, bus.err_rd_en, bus.pid_en,
         bus.act_we, timeout_err, overrun_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0",
               {busy, frame_done, bus.err_rd_en, bus.pid_en,
                bus.act_we, timeout_err, overrun_err});
    end
    vectors++;
    if ({bus.pid_err, bus.pid_kp, bus.act_data} !== 48'b0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0",
               {bus.pid_err, bus.pid_kp, bus.act_data});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    int base;
    int dbase;
    bit ok;
    for (int c = 0; c < NCH; c++) cfg_write(c, 0, 16);
    cfg_write(3, 0, 32);
    cfg_write(6, 0, 8);
    cfg_write(2, 1, 5);
    cfg_write(2, 2, -7);
    cfg_write(1, 3, 999);
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 49) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want 49",
               done_cyc - start_cyc);
    end
    vectors++;
    if (wa.size() - base != NCH) begin
      miscompares++;
      $display("FAIL basic_wr_count got %0d want %0d",
               wa.size() - base, NCH);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        vectors++;
        if (wa[base+i] !== 3'(i) ||
            wd[base+i] !== 16'(exp_a[i])) begin
          miscompares++;
          $display("FAIL basic_wr%0d got %0d:%0d want %0d:%0d",
                   i, wa[base+i], wd[base+i], i, exp_a[i]);
        end
      end
    end
    vectors++;
    if (seen_ki[2] !== 16'sd5 || seen_kd[2] !== -16'sd7) begin
      miscompares++;
      $display("FAIL basic_gains2 got %0d/%0d want 5/-7",
               seen_ki[2], seen_kd[2]);
    end
    vectors++;
    if (seen_kp[1] !== 16'sd16 || seen_ki[1] !== 16'sd0 ||
        seen_kd[1] !== 16'sd0) begin
      miscompares++;
      $display("FAIL sel3_dropped got %0d/%0d/%0d want 16/0/0",
               seen_kp[1], seen_ki[1], seen_kd[1]);
    end
    vectors++;
    if (busy !== 1'b0 || overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle got busy=%b ovr=%b want 0 0",
               busy, overrun_err);
    end
  endtask

  task automatic test_timeout();
    int base;
    int dbase;
    int idx [7] = '{0, 1, 2, 3, 4, 6, 7};
    bit ok;
    bit seen;
    drop_ch = 5;
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pid_en && cur_ch == 3'd5) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    repeat (30) tick();
    vectors++;
    if (!seen || bus.pid_err !== 16'sd1234 ||
        bus.pid_kp !== 16'sd16) begin
      miscompares++;
      $display("FAIL timeout_hold got %0d/%0d want 1234/16",
               bus.pid_err, bus.pid_kp);
    end
    wait_done(300, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 111) begin
      miscompares++;
      $display("FAIL timeout_latency got %0d want 111",
               done_cyc - start_cyc);
    end
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_flag got %b want 1", timeout_err);
    end
    vectors++;
    if (wa.size() - base != 7) begin
      miscompares++;
      $display("FAIL timeout_wr_count got %0d want 7",
               wa.size() - base);
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (wa[base+i] !== 3'(idx[i]) ||
            wd[base+i] !== 16'(exp_a[idx[i]])) begin
          miscompares++;
          $display("FAIL timeout_wr%0d got %0d:%0d want %0d:%0d",
                   i, wa[base+i], wd[base+i], idx[i],
                   exp_a[idx[i]]);
        end
      end
    end
    drop_ch = -1;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
  endtask

  task automatic test_overrun();
    int base;
    int dbase;
    bit ok;
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    repeat (8) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    vectors++;
    if (overrun_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flag got %b want 1", overrun_err);
    end
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 49) begin
      miscompares++;
      $display("FAIL overrun_latency got %0d want 49",
               done_cyc - start_cyc);
    end
    repeat (60) tick();
    vectors++;
    if (done_cnt != dbase + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_done_count got %0d want %0d",
               done_cnt - dbase, 1);
    end
    vectors++;
    if (wa.size() - base != NCH) begin
      miscompares++;
      $display("FAIL overrun_wr_count got %0d want %0d",
               wa.size() - base, NCH);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        vectors++;
        if (wa[base+i] !== 3'(i) ||
            wd[base+i] !== 16'(exp_a[i])) begin
          miscompares++;
          $display("FAIL overrun_wr%0d got %0d:%0d want %0d:%0d",
                   i, wa[base+i], wd[base+i], i, exp_a[i]);
        end
      end
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    vectors++;
    if (overrun_err !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear got %b want 0", overrun_err);
    end
    dbase = done_cnt;
    start_frame();
    repeat (3) tick();
    frame_start = 1'b1;
    clear_err = 1'b1;
    tick();
    frame_start = 1'b0;
    clear_err = 1'b0;
    vectors++;
    if (overrun_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set_wins got %b want 1",
               overrun_err);
    end
    wait_done(200, dbase, ok);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tick();
  endtask

  task automatic test_cfg_collision();
    int base;
    int dbase;
    bit ok;
    bit seen;
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.err_rd_en && bus.err_rd_addr == 3'd4) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tick();
    cfg_we = 1'b1;
    cfg_ch = 3'd4;
    cfg_sel = 2'd0;
    cfg_wdata = 16'sd48;
    tick();
    cfg_we = 1'b0;
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!seen || !ok || wa.size() - base != NCH ||
        wd[base+4] !== -16'sd40) begin
      miscompares++;
      $display("FAIL collide_old_kp got %0d want -40",
               (wa.size() - base == NCH) ? wd[base+4] : 16'sd0);
    end
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!ok || wa.size() - base != NCH ||
        wd[base+4] !== -16'sd120) begin
      miscompares++;
      $display("FAIL collide_new_kp got %0d want -120",
               (wa.size() - base == NCH) ? wd[base+4] : 16'sd0);
    end
  endtask

`ifdef PID_SCHED_CHMASK_EN
  task automatic test_chmask();
    int base;
    int dbase;
    int rbase;
    int idx [3] = '{0, 2, 7};
    bit ok;
    ch_mask = 8'b1000_0101;
    base = wa.size();
    dbase = done_cnt;
    rbase = rd_cnt;
    start_frame();
    ch_mask = '0;
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 19) begin
      miscompares++;
      $display("FAIL mask_latency got %0d want 19",
               done_cyc - start_cyc);
    end
    vectors++;
    if (rd_cnt - rbase != 3 || wa.size() - base != 3) begin
      miscompares++;
      $display("FAIL mask_counts got rd=%0d wr=%0d want 3 3",
               rd_cnt - rbase, wa.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wa[base+i] !== 3'(idx[i]) ||
            wd[base+i] !== 16'(exp_a[idx[i]])) begin
          miscompares++;
          $display("FAIL mask_wr%0d got %0d:%0d want %0d:%0d",
                   i, wa[base+i], wd[base+i], idx[i],
                   exp_a[idx[i]]);
        end
      end
    end
    base = wa.size();
    dbase = done_cnt;
    rbase = rd_cnt;
    start_frame();
    wait_done(20, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 2 ||
        wa.size() != base || rd_cnt != rbase) begin
      miscompares++;
      $display("FAIL mask_zero got lat=%0d wr=%0d want 2 0",
               done_cyc - start_cyc, wa.size() - base);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int base;
    int dbase;
    bit ok;
    bit seen;
    drop_ch = 3;
    start_frame();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pid_en && cur_ch == 3'd3) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!seen || {busy, bus.pid_en, bus.act_we,
                  bus.err_rd_en, frame_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL midrst_ctrl got %b want 0",
               {busy, bus.pid_en, bus.act_we,
                bus.err_rd_en, frame_done});
    end
    vectors++;
    if ({bus.pid_err, bus.pid_kp, bus.act_data,
         bus.act_addr, bus.err_rd_addr} !== 54'b0) begin
      miscompares++;
      $display("FAIL midrst_data got %h want 0",
               {bus.pid_err, bus.pid_kp, bus.act_data,
                bus.act_addr, bus.err_rd_addr});
    end
    tick();
    rst_n = 1'b1;
    drop_ch = -1;
    base = wa.size();
    dbase = done_cnt;
    start_frame();
    vectors++;
    if (bus.err_rd_en !== 1'b1 || bus.err_rd_addr !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_first_rd got %b@%0d want 1@0",
               bus.err_rd_en, bus.err_rd_addr);
    end
    wait_done(200, dbase, ok);
    tick();
    vectors++;
    if (!ok || done_cyc - start_cyc != 49 ||
        wa.size() - base != NCH) begin
      miscompares++;
      $display("FAIL midrst_frame got lat=%0d wr=%0d want 49 8",
               done_cyc - start_cyc, wa.size() - base);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        vectors++;
        if (wa[base+i] !== 3'(i) || wd[base+i] !== 16'sd0) begin
          miscompares++;
          $display("FAIL midrst_wr%0d got %0d:%0d want %0d:0",
                   i, wa[base+i], wd[base+i], i);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++)
      err_mem[i] = 16'(exp_a[i]);
    err_mem[3] = 16'sd33;
    err_mem[6] = 16'sd500;
    test_reset();
    test_basic_frame();
    test_timeout();
    test_overrun();
    test_cfg_collision();
`ifdef PID_SCHED_CHMASK_EN
    test_chmask();
`endif
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pid_channel_scheduler.md
Name: pid_channel_scheduler

Overview:
- Time-multiplexes one shared PID datapath across NUM_CH deformable-mirror actuator channels.
- On each frame_start it walks the channels in ascending order, repeating five steps per channel:
  - read the channel's wavefront error from the sensor buffer;
  - load that channel's kp/ki/kd from an internal gain bank;
  - fire the PID for one cycle and wait for its out_valid;
  - write the result to the actuator command buffer;
  - advance to the next channel.
- Sits between the wavefront-sensor error buffer, the PID datapath and the actuator DAC buffer.

Parameters:
- NUM_CH, 8, number of actuator channels (2..256).
- CH_W, 3, channel index width; must satisfy 2**CH_W >= NUM_CH.
- TIMEOUT_CYC, 64, max cycles spent in WAIT_PID before the channel is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse that starts a frame.
- busy  out  1  high from the cycle after an accepted frame_start through DONE.
- frame_done  out  1  one-cycle pulse when the last channel has been written.
- err_rd_en  out  1  sensor buffer read strobe.
- err_rd_addr  out  CH_W  sensor buffer read address.
- err_rd_data  in  16 signed  error sample, valid exactly 1 cycle after err_rd_en.
- pid_en  out  1  one-cycle fire pulse to the PID.
- pid_err  out  16 signed  error presented to the PID, held stable while in WAIT_PID.
- pid_kp, pid_ki, pid_kd  out  16 signed each  gains, held stable while in WAIT_PID.
- pid_valid  in  1  PID result strobe.
- pid_out  in  16 signed  PID result, sampled when pid_valid=1.
- act_we  out  1  actuator buffer write strobe.
- act_addr  out  CH_W  actuator buffer address.
- act_data  out  16 signed  actuator command.
- cfg_we  in  1  gain bank write strobe.
- cfg_ch  in  CH_W  channel to configure.
- cfg_sel  in  2  gain select: 0=kp, 1=ki, 2=kd; 3 is ignored.
- cfg_wdata  in  16 signed  gain value.
- clear_err  in  1  one-cycle pulse that clears the sticky flags.
- timeout_err  out  1  sticky: a PID result did not arrive within TIMEOUT_CYC.
- overrun_err  out  1  sticky: frame_start arrived while busy.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE; every output is 0; the gain bank is cleared to 0; the channel counter is 0.
- State sequence:
  - IDLE: on frame_start go to RD_ERR with ch=0.
  - RD_ERR: err_rd_en=1 and err_rd_addr=ch for exactly 1 cycle, then go to CAPTURE.
  - CAPTURE: register err_rd_data into pid_err and the bank gains for ch into pid_kp/ki/kd, then go to ISSUE.
  - ISSUE: pid_en=1 for 1 cycle; clear the timeout counter; go to WAIT_PID.
  - WAIT_PID:
    - On pid_valid, latch pid_out into act_data and go to WRITE.
    - If the counter reaches TIMEOUT_CYC-1 without pid_valid, set timeout_err, skip the write and go to NEXT.
  - WRITE: act_we=1 and act_addr=ch for 1 cycle, then go to NEXT.
  - NEXT:
    - If ch==NUM_CH-1, go to DONE.
    - Otherwise increment ch and go to RD_ERR.
  - DONE: frame_done=1 for 1 cycle, busy drops, go to IDLE.
- Handshake timing:
  - pid_valid is ignored in every state except WAIT_PID.
  - pid_valid in the same cycle as pid_en (ISSUE) is not accepted.
  - Minimum per-channel cost with a 1-cycle PID response: RD_ERR, CAPTURE, ISSUE, WAIT_PID, WRITE, NEXT = 6 cycles.
  - Frame with a 1-cycle PID response: 6*NUM_CH + 1 cycles from frame_start to frame_done (49 cycles for NUM_CH=8).
- Overrun: frame_start while busy is ignored and sets overrun_err. The current frame continues unaffected.
- Sticky flags: clear_err clears both flags. A set event in the same cycle as clear_err wins, so the flag reads 1.
- Gain bank:
  - Written on any cycle, busy or idle.
  - A write to ch in the same cycle as CAPTURE for ch: CAPTURE takes the old value; the new value applies from the next frame.
  - Writes to cfg_ch >= NUM_CH and writes with cfg_sel=3 are dropped.
- Channel counter: wraps only via DONE to IDLE. No arithmetic is performed on data; it is passed through unchanged.

Optional Feature:
- Macro: PID_SCHED_CHMASK_EN.
- When defined:
  - Adds input ch_mask [NUM_CH-1:0], sampled once when frame_start is accepted.
  - In NEXT the scheduler jumps directly to the next set bit; channels with a cleared bit get no err read, no pid_en and no act write.
  - An all-zero mask goes IDLE, then DONE, then frame_done the following cycle.
- When undefined: the port is absent and all channels are processed.

Test Plan:
- Reset mid-frame: assert rst_n=0 while in WAIT_PID at ch=3 -> all outputs 0 immediately; a following frame starts again at ch=0.
- NUM_CH=8; gains for ch2 = kp 16, ki 0, kd 0; err[2]=100; PID model echoes err*kp>>4 after 1 cycle -> act_addr=2 with act_data=100; frame_done exactly 49 cycles after frame_start.
- PID model never asserts pid_valid for ch5 -> timeout_err=1 after 64 WAIT_PID cycles; no act_we for ch5; ch6 and ch7 are still written; clear_err then drops the flag.
- frame_start pulsed at cycle 10 of a busy frame -> overrun_err=1; only one frame_done occurs; the write sequence is unchanged.
- cfg_we for ch4 kp coincident with CAPTURE of ch4 -> that frame uses the old kp; the next frame uses the new kp.
- With PID_SCHED_CHMASK_EN and ch_mask=8'b1000_0101 -> writes only to ch0, ch2 and ch7; with mask=0, frame_done arrives 2 cycles after frame_start.
